// File: rtl/fetch_queue_pkg.sv
// Shared fetch/decode types: the IF/ID packet and the default fetch-queue depth.
package fetch_queue_pkg;

    localparam int FQ_DEPTH = 8;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] npc;
        logic [31:0] inst;
        logic [1:0]  bp_state;
        logic        bp_hit;
    } If_id_pkt_t;

endpackage

// File: rtl/fetch_queue.sv
// Two-wide circular instruction buffer between fetch and decode. It accepts up to two
// packets per cycle and presents the two oldest to decode, with no enqueue bypass.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = FQ_DEPTH,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic [1:0]            enq_valid,
    input  If_id_pkt_t [1:0]      enq_pkt,
    output logic                  enq_rdy,
    output logic [1:0]            deq_valid,
    output If_id_pkt_t [1:0]      deq_pkt,
    input  logic [1:0]            deq_en,
    output logic [PTR_W:0]        count,
    output logic                  proto_err
);

    If_id_pkt_t       mem_q [DEPTH];
    logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
    logic [PTR_W-1:0] head_p1, tail_p1;
    logic [PTR_W:0]   count_q, count_d;
    logic             proto_err_q, proto_err_d;
    logic             wr0, wr1, dq0, dq1;
    logic [1:0]       n_enq, n_deq;

    // DEPTH is a power of two, so pointer arithmetic wraps naturally at PTR_W bits.
    assign head_p1   = head_q + PTR_W'(1);
    assign tail_p1   = tail_q + PTR_W'(1);

    assign enq_rdy   = (count_q <= (PTR_W+1)'(DEPTH - 2));
    assign deq_valid = {count_q >= (PTR_W+1)'(2), count_q >= (PTR_W+1)'(1)};
    assign deq_pkt   = {mem_q[head_p1], mem_q[head_q]};
    assign count     = count_q;
    assign proto_err = proto_err_q;

    always_comb begin
        // A lone upper bit (2'b10) is illegal and leaves both counts at zero.
        wr0 = enq_rdy & enq_valid[0] & ~flush;
        wr1 = wr0 & enq_valid[1];
        dq0 = deq_en[0] & deq_valid[0];
        dq1 = dq0 & deq_en[1] & deq_valid[1];
        n_enq = {1'b0, wr0} + {1'b0, wr1};
        n_deq = {1'b0, dq0} + {1'b0, dq1};

        head_d  = head_q + PTR_W'(n_deq);
        tail_d  = tail_q + PTR_W'(n_enq);
        count_d = count_q + (PTR_W+1)'(n_enq) - (PTR_W+1)'(n_deq);
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end

        proto_err_d = proto_err_q | (enq_valid == 2'b10) | (deq_en == 2'b10);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q      <= '0;
            tail_q      <= '0;
            count_q     <= '0;
            proto_err_q <= 1'b0;
        end else begin
            head_q      <= head_d;
            tail_q      <= tail_d;
            count_q     <= count_d;
            proto_err_q <= proto_err_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (wr0) mem_q[tail_q]  <= enq_pkt[0];
            if (wr1) mem_q[tail_p1] <= enq_pkt[1];
        end
    end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed vector table, protocol/reset sequences, and random
// traffic compared against a queue-based reference model.
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    localparam int DEPTH = FQ_DEPTH;
    localparam int PTR_W = $clog2(DEPTH);

    logic             clk = 1'b0;
    logic             rst;
    logic             flush;
    logic [1:0]       enq_valid;
    If_id_pkt_t [1:0] enq_pkt;
    logic             enq_rdy;
    logic [1:0]       deq_valid;
    If_id_pkt_t [1:0] deq_pkt;
    logic [1:0]       deq_en;
    logic [PTR_W:0]   count;
    logic             proto_err;

    int checks = 0;
    int failures = 0;

    fetch_queue #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk(clk), .rst(rst), .flush(flush),
        .enq_valid(enq_valid), .enq_pkt(enq_pkt), .enq_rdy(enq_rdy),
        .deq_valid(deq_valid), .deq_pkt(deq_pkt), .deq_en(deq_en),
        .count(count), .proto_err(proto_err)
    );

    always #5 clk = ~clk;

    // Reference model: an ordered list of live packets plus a sticky error flag.
    If_id_pkt_t mq[$];
    logic       m_err;

    typedef struct {
        logic        f;
        logic [1:0]  ev;
        logic [1:0]  de;
        logic [31:0] pc;
        int          cnt;
        logic [1:0]  dv;
        logic        rdy;
        logic [31:0] pc0;
        logic [31:0] pc1;
    } vec_t;

    vec_t vt[18];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic chk_pkt(input string name, input If_id_pkt_t act, input If_id_pkt_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    function automatic If_id_pkt_t mk(input logic [31:0] pc);
        If_id_pkt_t p;
        p.pc       = pc;
        p.npc      = pc + 32'd4;
        p.inst     = ~pc;
        p.bp_state = pc[2:1];
        p.bp_hit   = pc[3];
        return p;
    endfunction

    function automatic If_id_pkt_t rnd_pkt();
        If_id_pkt_t p;
        p.pc       = $urandom;
        p.npc      = $urandom;
        p.inst     = $urandom;
        p.bp_state = 2'($urandom_range(0, 3));
        p.bp_hit   = 1'($urandom_range(0, 1));
        return p;
    endfunction

    task automatic model_step(input logic f, input logic [1:0] ev, input logic [1:0] de,
                              input If_id_pkt_t p0, input If_id_pkt_t p1);
        int sz;
        int nd;
        sz = mq.size();
        if (ev == 2'b10 || de == 2'b10) m_err = 1'b1;
        if (f) begin
            mq.delete();
        end else begin
            nd = (de[0] && sz >= 1) ? ((de[1] && sz >= 2) ? 2 : 1) : 0;
            for (int i = 0; i < nd; i++) void'(mq.pop_front());
            if (sz <= DEPTH - 2 && ev[0]) begin
                mq.push_back(p0);
                if (ev[1]) mq.push_back(p1);
            end
        end
    endtask

    task automatic drive(input logic f, input logic [1:0] ev, input logic [1:0] de,
                         input If_id_pkt_t p0, input If_id_pkt_t p1);
        flush      = f;
        enq_valid  = ev;
        deq_en     = de;
        enq_pkt[0] = p0;
        enq_pkt[1] = p1;
        @(posedge clk);
        model_step(f, ev, de, p0, p1);
        #1;
    endtask

    task automatic check_model(input string tag);
        int sz;
        sz = mq.size();
        chk({tag, ".count"}, 64'(count), 64'(sz));
        chk({tag, ".deq_valid"}, 64'(deq_valid), {62'd0, sz >= 2, sz >= 1});
        chk({tag, ".enq_rdy"}, 64'(enq_rdy), 64'(sz <= DEPTH - 2));
        chk({tag, ".proto_err"}, 64'(proto_err), 64'(m_err));
        if (sz >= 1) chk_pkt({tag, ".pkt0"}, deq_pkt[0], mq[0]);
        if (sz >= 2) chk_pkt({tag, ".pkt1"}, deq_pkt[1], mq[1]);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        flush = 1'b0; enq_valid = 2'b00; deq_en = 2'b00;
        enq_pkt[0] = '0; enq_pkt[1] = '0;
        mq.delete();
        m_err = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int r;
        logic [1:0] ev, de;
        logic f;

        vt[0]  = '{1'b0, 2'b11, 2'b00, 32'h100, 2, 2'b11, 1'b1, 32'h100, 32'h102};
        vt[1]  = '{1'b0, 2'b11, 2'b00, 32'h104, 4, 2'b11, 1'b1, 32'h100, 32'h102};
        vt[2]  = '{1'b0, 2'b11, 2'b00, 32'h108, 6, 2'b11, 1'b1, 32'h100, 32'h102};
        vt[3]  = '{1'b0, 2'b11, 2'b00, 32'h10c, 8, 2'b11, 1'b0, 32'h100, 32'h102};
        vt[4]  = '{1'b0, 2'b11, 2'b00, 32'h200, 8, 2'b11, 1'b0, 32'h100, 32'h102};
        vt[5]  = '{1'b0, 2'b00, 2'b01, 32'h0,   7, 2'b11, 1'b0, 32'h102, 32'h104};
        vt[6]  = '{1'b0, 2'b00, 2'b11, 32'h0,   5, 2'b11, 1'b1, 32'h106, 32'h108};
        vt[7]  = '{1'b0, 2'b11, 2'b00, 32'h110, 7, 2'b11, 1'b0, 32'h106, 32'h108};
        vt[8]  = '{1'b0, 2'b00, 2'b11, 32'h0,   5, 2'b11, 1'b1, 32'h10a, 32'h10c};
        vt[9]  = '{1'b0, 2'b00, 2'b11, 32'h0,   3, 2'b11, 1'b1, 32'h10e, 32'h110};
        vt[10] = '{1'b0, 2'b00, 2'b11, 32'h0,   1, 2'b01, 1'b1, 32'h112, 32'h0};
        vt[11] = '{1'b0, 2'b00, 2'b11, 32'h0,   0, 2'b00, 1'b1, 32'h0,   32'h0};
        vt[12] = '{1'b0, 2'b11, 2'b00, 32'h300, 2, 2'b11, 1'b1, 32'h300, 32'h302};
        vt[13] = '{1'b0, 2'b01, 2'b00, 32'h304, 3, 2'b11, 1'b1, 32'h300, 32'h302};
        vt[14] = '{1'b0, 2'b11, 2'b11, 32'h308, 3, 2'b11, 1'b1, 32'h304, 32'h308};
        vt[15] = '{1'b0, 2'b11, 2'b00, 32'h30c, 5, 2'b11, 1'b1, 32'h304, 32'h308};
        vt[16] = '{1'b1, 2'b11, 2'b11, 32'h500, 0, 2'b00, 1'b1, 32'h0,   32'h0};
        vt[17] = '{1'b0, 2'b01, 2'b00, 32'h400, 1, 2'b01, 1'b1, 32'h400, 32'h0};

        do_reset();
        #1;
        chk("rst.count", 64'(count), 64'd0);
        chk("rst.deq_valid", 64'(deq_valid), 64'd0);
        chk("rst.enq_rdy", 64'(enq_rdy), 64'd1);
        chk("rst.proto_err", 64'(proto_err), 64'd0);
        chk("rst.deq_pkt", 64'(deq_pkt[0] | deq_pkt[1]), 64'd0);

        for (int i = 0; i < 18; i++) begin
            drive(vt[i].f, vt[i].ev, vt[i].de, mk(vt[i].pc), mk(vt[i].pc + 32'd2));
            chk($sformatf("vec%0d.count", i), 64'(count), 64'(vt[i].cnt));
            chk($sformatf("vec%0d.deq_valid", i), 64'(deq_valid), 64'(vt[i].dv));
            chk($sformatf("vec%0d.enq_rdy", i), 64'(enq_rdy), 64'(vt[i].rdy));
            if (vt[i].dv[0]) chk_pkt($sformatf("vec%0d.pkt0", i), deq_pkt[0], mk(vt[i].pc0));
            if (vt[i].dv[1]) chk_pkt($sformatf("vec%0d.pkt1", i), deq_pkt[1], mk(vt[i].pc1));
        end
        chk("vec.proto_err", 64'(proto_err), 64'd0);

        // Illegal enqueue pattern: ignored but flagged, then held.
        drive(1'b0, 2'b10, 2'b00, mk(32'h600), mk(32'h602));
        chk("perr_enq.count", 64'(count), 64'd1);
        chk("perr_enq.proto_err", 64'(proto_err), 64'd1);
        drive(1'b0, 2'b11, 2'b00, mk(32'h604), mk(32'h606));
        drive(1'b0, 2'b00, 2'b10, mk(32'h0), mk(32'h0));
        chk("perr_deq.count", 64'(count), 64'd3);
        chk_pkt("perr_deq.pkt0", deq_pkt[0], mk(32'h400));
        chk("perr_hold.proto_err", 64'(proto_err), 64'd1);

        // Asynchronous reset clears state before any clock edge.
        flush = 1'b0; enq_valid = 2'b00; deq_en = 2'b00;
        #2;
        rst = 1'b0;
        #1;
        chk("arst.proto_err", 64'(proto_err), 64'd0);
        chk("arst.count", 64'(count), 64'd0);
        chk("arst.deq_valid", 64'(deq_valid), 64'd0);

        // Random traffic against the reference model.
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            r  = $urandom_range(0, 99);
            ev = (r < 2) ? 2'b10 : (r < 35) ? 2'b00 : (r < 60) ? 2'b01 : 2'b11;
            r  = $urandom_range(0, 99);
            de = (r < 2) ? 2'b10 : (r < 40) ? 2'b00 : (r < 65) ? 2'b01 : 2'b11;
            f  = ($urandom_range(0, 99) < 3);
            drive(f, ev, de, rnd_pkt(), rnd_pkt());
            check_model($sformatf("rnd%0d", c));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
